// File: rtl/alu_writeback_pkg.sv
// Shared types, widths and helpers for the ALU writeback stage.
package alu_writeback_pkg;

    localparam int WIDTH = 16;   // datapath width
    localparam int ADDRW = 4;    // register-file address width
    localparam int OPW   = 5;    // opcode width, same encoding as the ALU
    localparam int CNTW  = 16;   // retired-op counter width

    // Bit positions inside the {Z,N,C,V} status word
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Opcodes at or above this value are not ALU-class and never touch the flags
    localparam logic [OPW-1:0] OP_NOFLAG_BASE = 5'h10;

    typedef logic [3:0] flags_t;

    // One buffered op: everything needed to write back and commit flags later
    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [ADDRW-1:0] dest;
        logic             write_en;
        logic [WIDTH-1:0] result;
        flags_t           flags;
    } wb_entry_t;

    // Build the status word at capture time; Z is derived from the result itself
    function automatic flags_t make_flags(
        input logic [WIDTH-1:0] result,
        input logic             negative,
        input logic             carry,
        input logic             overflow
    );
        flags_t f;
        f         = 4'b0000;
        f[FLAG_Z] = (result == {WIDTH{1'b0}});
        f[FLAG_N] = negative;
        f[FLAG_C] = carry;
        f[FLAG_V] = overflow;
        return f;
    endfunction

    // True for ALU-class opcodes whose status is committed on retire
    function automatic logic commits_flags(input logic [OPW-1:0] opcode);
        return (opcode < OP_NOFLAG_BASE);
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Bundle of the upstream op handshake and the register-file write port.
interface alu_writeback_if;
    import alu_writeback_pkg::*;

    // Upstream op handshake plus ALU outputs
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [ADDRW-1:0] in_dest;
    logic             in_write_en;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             flush;

    // Register-file write port and status outputs
    logic             reg_write;
    logic [ADDRW-1:0] reg_addr;
    logic [WIDTH-1:0] reg_data;
    logic             reg_ready;
    flags_t           flags;
    logic [CNTW-1:0]  retire_count;

    // Driver side: issues ops and models the register file
    modport master (
        output in_valid, in_opcode, in_dest, in_write_en,
        output result, carry, negative, overflow, flush, reg_ready,
        input  in_ready, reg_write, reg_addr, reg_data, flags, retire_count
    );

    // Writeback stage side
    modport slave (
        input  in_valid, in_opcode, in_dest, in_write_en,
        input  result, carry, negative, overflow, flush, reg_ready,
        output in_ready, reg_write, reg_addr, reg_data, flags, retire_count
    );

endinterface

// File: rtl/alu_writeback_fifo2.sv
// Two-entry op buffer with push/pop/flush; head entry is presented combinationally.
module alu_writeback_fifo2
    import alu_writeback_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t push_entry,
    output wb_entry_t head_entry,
    output logic      head_valid,
    output logic [1:0] count
);

    wb_entry_t  mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] count_r;
    logic       push_ok_s;
    logic       pop_ok_s;

    // Qualify push/pop: flush overrides both, and full/empty are never over/under-run
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = push && (count_r < 2'd2);
            pop_ok_s  = pop && (count_r != 2'd0);
        end
    end

    // Entry storage, written at the tail pointer on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers wrap modulo 2; occupancy tracks push/pop, flush empties everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view straight from storage; no bypass of the incoming entry
    always_comb begin
        head_entry = mem_r[rd_ptr_r];
        head_valid = (count_r != 2'd0);
        count      = count_r;
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: buffers up to two ops, writes the
// register file in order, commits {Z,N,C,V} and counts retired ops.
module alu_writeback
    import alu_writeback_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_writeback_if.slave bus
);

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    wb_entry_t       in_entry_s;
    wb_entry_t       head_s;
    logic            head_valid_s;
    logic [1:0]      count_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            retire_s;
    flags_t          flags_r;
    logic [CNTW-1:0] retire_count_r;

    // Package the incoming op, computing Z from the result at capture time
    always_comb begin
        in_entry_s.opcode   = bus.in_opcode;
        in_entry_s.dest     = bus.in_dest;
        in_entry_s.write_en = bus.in_write_en;
        in_entry_s.result   = bus.result;
        in_entry_s.flags    = make_flags(bus.result, bus.negative, bus.carry, bus.overflow);
    end

    // Handshake: ready depends only on occupancy; non-writing ops retire without the register file
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        retire_s   = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (count_s < 2'd2);
        end
        accept_s = bus.in_valid && in_ready_s;
        if (bus.flush) begin
            retire_s = 1'b0;
        end else begin
            retire_s = head_valid_s && (bus.reg_ready || !head_s.write_en);
        end
    end

    alu_writeback_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept_s),
        .pop        (retire_s),
        .flush      (bus.flush),
        .push_entry (in_entry_s),
        .head_entry (head_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    // Commit flags of ALU-class ops as they retire; flush suppresses the commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'b0000;
        end else if (retire_s && commits_flags(head_s.opcode)) begin
            flags_r <= head_s.flags;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Count every retired op, wrapping at the counter width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_r <= {CNTW{1'b0}};
        end else if (retire_s) begin
            retire_count_r <= retire_count_r + CNT_ONE;
        end else begin
            retire_count_r <= retire_count_r;
        end
    end

    // Drive the register-file port from the buffered head; zeros when nothing is buffered
    always_comb begin
        bus.in_ready     = in_ready_s;
        bus.reg_write    = 1'b0;
        bus.reg_addr     = {ADDRW{1'b0}};
        bus.reg_data     = {WIDTH{1'b0}};
        bus.flags        = flags_r;
        bus.retire_count = retire_count_r;
        if (head_valid_s) begin
            bus.reg_write = head_s.write_en;
            bus.reg_addr  = head_s.dest;
            bus.reg_data  = head_s.result;
        end else begin
            bus.reg_write = 1'b0;
            bus.reg_addr  = {ADDRW{1'b0}};
            bus.reg_data  = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   guard;

    alu_writeback_if bus ();

    alu_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] dest, input logic we,
                         input logic [15:0] res, input logic c, input logic n, input logic v);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = op;
        bus.in_dest     = dest;
        bus.in_write_en = we;
        bus.result      = res;
        bus.carry       = c;
        bus.negative    = n;
        bus.overflow    = v;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // One clock elapses; inputs are changed and outputs sampled at the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_opcode = 5'h00; bus.in_dest = 4'h0; bus.in_write_en = 1'b0;
        bus.result = 16'h0000; bus.carry = 1'b0; bus.negative = 1'b0; bus.overflow = 1'b0;
        bus.flush = 1'b0; bus.reg_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_reg_data", bus.reg_data, 0);
        chk("rst_flags", bus.flags, 0);
        chk("rst_count", bus.retire_count, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_reg_write", bus.reg_write, 0);

        // Single op: zero result with carry -> Z and C
        bus.reg_ready = 1'b1;
        drive(5'h01, 4'd3, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(); idle();
        chk("single_reg_write", bus.reg_write, 1);
        chk("single_reg_addr", bus.reg_addr, 3);
        chk("single_reg_data", bus.reg_data, 16'h0000);
        chk("single_flags_before", bus.flags, 4'b0000);
        step();
        chk("single_flags", bus.flags, 4'b1010);
        chk("single_count", bus.retire_count, 1);
        chk("single_idle_write", bus.reg_write, 0);

        // Negative result sets Flags to 0100
        drive(5'h02, 4'd1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        step(); idle();
        chk("neg_reg_addr", bus.reg_addr, 1);
        step();
        chk("neg_flags", bus.flags, 4'b0100);
        chk("neg_count", bus.retire_count, 2);

        // Non-ALU opcode is written but leaves Flags alone
        drive(5'h12, 4'd5, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
        step(); idle();
        chk("noflag_reg_write", bus.reg_write, 1);
        chk("noflag_reg_addr", bus.reg_addr, 5);
        chk("noflag_reg_data", bus.reg_data, 16'h8000);
        step();
        chk("noflag_flags", bus.flags, 4'b0100);
        chk("noflag_count", bus.retire_count, 3);

        // Non-writing op retires without RegReady and commits V
        bus.reg_ready = 1'b0;
        drive(5'h03, 4'd7, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
        step(); idle();
        chk("nowrite_reg_write", bus.reg_write, 0);
        step();
        chk("nowrite_flags", bus.flags, 4'b0001);
        chk("nowrite_count", bus.retire_count, 4);

        // Backpressure: two buffered, third held until a slot frees
        drive(5'h04, 4'd8, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'h05, 4'd9, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_full_ready", bus.in_ready, 0);
        drive(5'h06, 4'd10, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_held_ready", bus.in_ready, 0);
        chk("bp_head_write", bus.reg_write, 1);
        chk("bp_head_addr", bus.reg_addr, 8);
        chk("bp_head_data", bus.reg_data, 16'h1111);
        chk("bp_count_stalled", bus.retire_count, 4);
        bus.reg_ready = 1'b1;
        step();
        chk("bp_count_1st", bus.retire_count, 5);
        chk("bp_ready_again", bus.in_ready, 1);
        chk("bp_head2_addr", bus.reg_addr, 9);
        chk("bp_head2_data", bus.reg_data, 16'h2222);
        step(); idle();
        chk("bp_count_2nd", bus.retire_count, 6);
        chk("bp_head3_addr", bus.reg_addr, 10);
        chk("bp_head3_data", bus.reg_data, 16'h3333);
        step();
        chk("bp_count_3rd", bus.retire_count, 7);
        chk("bp_drained_write", bus.reg_write, 0);
        chk("bp_flags", bus.flags, 4'b0000);

        // Flush with count=1 and a same-edge accept
        bus.reg_ready = 1'b0;
        drive(5'h01, 4'd2, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        step();
        chk("fl_pre_addr", bus.reg_addr, 2);
        drive(5'h01, 4'd3, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        bus.reg_ready = 1'b1;
        #1;
        chk("fl_cycle_write", bus.reg_write, 1);
        step();
        bus.flush = 1'b0; idle();
        chk("fl_empty_write", bus.reg_write, 0);
        chk("fl_count", bus.retire_count, 7);
        chk("fl_flags", bus.flags, 4'b0000);
        step();
        chk("fl_dropped_count", bus.retire_count, 7);
        chk("fl_dropped_write", bus.reg_write, 0);

        // Counter wrap with a stream of non-writing, non-flag ops
        drive(5'h1F, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        guard = 0;
        while (bus.retire_count !== 16'hFFFF && guard < 70000) begin
            step();
            guard++;
        end
        idle();
        chk("wrap_reach", bus.retire_count, 16'hFFFF);
        chk("wrap_flags_kept", bus.flags, 4'b0000);
        step();
        chk("wrap_zero", bus.retire_count, 16'h0000);
        chk("wrap_flags_after", bus.flags, 4'b0000);

        // Reset mid-stream with two ops buffered
        bus.reg_ready = 1'b0;
        drive(5'h03, 4'd0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
        step();
        drive(5'h01, 4'd4, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'h01, 4'd6, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        step(); idle();
        chk("mid_full_ready", bus.in_ready, 0);
        chk("mid_write", bus.reg_write, 1);
        chk("mid_flags", bus.flags, 4'b0001);
        chk("mid_count", bus.retire_count, 1);
        rst = 1'b1;
        bus.reg_ready = 1'b1;
        #1;
        chk("mid_rst_write", bus.reg_write, 0);
        chk("mid_rst_flags", bus.flags, 0);
        chk("mid_rst_count", bus.retire_count, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rel_ready", bus.in_ready, 1);
        chk("mid_rel_write", bus.reg_write, 0);
        chk("mid_rel_count", bus.retire_count, 0);
        chk("mid_rel_flags", bus.flags, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
